// File: rtl/pmp_pkg.sv
// pmp_pkg: shared PMP config layout, address-mode and privilege constants
package pmp_pkg;
  typedef struct packed {
    logic       l;
    logic [1:0] res;
    logic [1:0] a;
    logic       x;
    logic       w;
    logic       r;
  } pmpcfg_t;
  localparam logic [1:0] A_OFF   = 2'd0;
  localparam logic [1:0] A_TOR   = 2'd1;
  localparam logic [1:0] A_NA4   = 2'd2;
  localparam logic [1:0] A_NAPOT = 2'd3;
  localparam logic [1:0] PRV_U   = 2'd0;
  localparam logic [1:0] PRV_S   = 2'd1;
  localparam logic [1:0] PRV_M   = 2'd3;
endpackage

// File: rtl/pmp_entry_match.sv
// pmp_entry_match: combinational address match of one PMP entry for the first and last byte of an access
// Ports: mode_i (A field), addr_i (this pmpaddr), prev_i (previous pmpaddr, TOR lower bound),
//        first_i/last_i (byte addresses), first_hit_o/last_hit_o (byte inside region).
// Build option PMP_NAPOT_EN: when undefined, mode NAPOT matches nothing.
module pmp_entry_match
  import pmp_pkg::*;
#(
  parameter int PLEN = 34
) (
  input  logic [1:0]      mode_i,
  input  logic [PLEN-3:0] addr_i,
  input  logic [PLEN-3:0] prev_i,
  input  logic [PLEN-1:0] first_i,
  input  logic [PLEN-1:0] last_i,
  output logic            first_hit_o,
  output logic            last_hit_o
);
  logic [1:0]      mode;
  logic [PLEN-3:0] napot_mask;
`ifdef PMP_NAPOT_EN
  assign mode = mode_i;
`else
  assign mode = (mode_i == A_NAPOT) ? A_OFF : mode_i;
`endif
  // trailing ones of pmpaddr plus the next bit form the don't-care word-address bits
  assign napot_mask = ~(addr_i ^ (addr_i + 1'b1));
  function automatic logic covers(input logic [1:0] m, input logic [PLEN-3:0] ad, input logic [PLEN-3:0] pv,
                                  input logic [PLEN-3:0] mk, input logic [PLEN-1:0] a);
    return (m == A_TOR)   ? (a >= {pv, 2'b00} && a < {ad, 2'b00}) :
           (m == A_NA4)   ? (a[PLEN-1:2] == ad) :
           (m == A_NAPOT) ? ((a[PLEN-1:2] & mk) == (ad & mk)) : 1'b0;
  endfunction
  assign first_hit_o = covers(mode, addr_i, prev_i, napot_mask, first_i);
  assign last_hit_o  = covers(mode, addr_i, prev_i, napot_mask, last_i);
endmodule

// File: rtl/pmp_checker.sv
// pmp_checker: PMP CSR file plus two-stage access checker (S1 capture, registered response)
// Ports: clk_i/rst_i (sync active-high); csr_* write/read pmpcfg (sel=0) or pmpaddr (sel=1);
//        req_* access request (valid/ready); rsp_* response (valid/ready) with exception, hit, idx.
// Build option PMP_NAPOT_EN: enables NAPOT matching (otherwise NAPOT entries behave as OFF).
module pmp_checker
  import pmp_pkg::*;
#(
  parameter int PMP_CNT = 16,
  parameter int PLEN    = 34,
  parameter int IDX_W   = (PMP_CNT > 1) ? $clog2(PMP_CNT) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             csr_we_i,
  input  logic             csr_sel_i,
  input  logic [IDX_W-1:0] csr_idx_i,
  input  logic [31:0]      csr_wdata_i,
  output logic [31:0]      csr_rdata_o,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [PLEN-1:0]  req_addr_i,
  input  logic [1:0]       req_size_i,
  input  logic [1:0]       req_prv_i,
  input  logic             req_r_i,
  input  logic             req_w_i,
  input  logic             req_x_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_exception_o,
  output logic             rsp_hit_o,
  output logic [IDX_W-1:0] rsp_idx_o
);
  localparam int AW = PLEN - 2;
  pmpcfg_t         cfg_q [PMP_CNT];
  pmpcfg_t         cfg_d [PMP_CNT];
  logic [AW-1:0]   addr_q[PMP_CNT];
  logic [AW-1:0]   addr_d[PMP_CNT];
  logic [PMP_CNT-1:0] addr_lock, first_hit, last_hit;
  pmpcfg_t         wcfg;
  logic            s1_valid_q, s1_r_q, s1_w_q, s1_x_q;
  logic [PLEN-1:0] s1_addr_q, last_addr;
  logic [1:0]      s1_size_q, s1_prv_q;
  logic            rsp_valid_q, rsp_exc_q, rsp_hit_q;
  logic [IDX_W-1:0] rsp_idx_q, sel_idx;
  logic            sel_hit, sel_full, sel_bad, sel_l, exc, advance;
  // W without R is reserved, so W is dropped in that case
  assign wcfg = '{l: csr_wdata_i[7], res: 2'b00, a: csr_wdata_i[4:3], x: csr_wdata_i[2],
                  w: csr_wdata_i[1] & csr_wdata_i[0], r: csr_wdata_i[0]};
  assign csr_rdata_o = csr_sel_i ? 32'(addr_q[csr_idx_i]) : {24'b0, cfg_q[csr_idx_i]};
  always_comb begin
    cfg_d  = cfg_q;
    addr_d = addr_q;
    if (csr_we_i && !csr_sel_i && !cfg_q[csr_idx_i].l) cfg_d[csr_idx_i] = wcfg;
    if (csr_we_i && csr_sel_i && !addr_lock[csr_idx_i]) addr_d[csr_idx_i] = AW'(csr_wdata_i);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < PMP_CNT; k++) begin
        cfg_q[k]  <= '0;
        addr_q[k] <= '0;
      end
    end else begin
      cfg_q  <= cfg_d;
      addr_q <= addr_d;
    end
  end
  assign last_addr = s1_addr_q + (PLEN'(1) << s1_size_q) - PLEN'(1);
  for (genvar i = 0; i < PMP_CNT; i++) begin : g_entry
    logic [AW-1:0] prev;
    if (i == 0) begin : g_lo
      assign prev = '0;
    end else begin : g_lo
      assign prev = addr_q[i-1];
    end
    // a locked TOR entry above also freezes this entry's address (its lower bound)
    if (i == PMP_CNT - 1) begin : g_lk
      assign addr_lock[i] = cfg_q[i].l;
    end else begin : g_lk
      assign addr_lock[i] = cfg_q[i].l | (cfg_q[i+1].l & (cfg_q[i+1].a == A_TOR));
    end
    pmp_entry_match #(.PLEN(PLEN)) u_match (
      .mode_i     (cfg_q[i].a),
      .addr_i     (addr_q[i]),
      .prev_i     (prev),
      .first_i    (s1_addr_q),
      .last_i     (last_addr),
      .first_hit_o(first_hit[i]),
      .last_hit_o (last_hit[i])
    );
  end
  // descending scan so the lowest matching index wins
  always_comb begin
    sel_hit  = 1'b0;
    sel_idx  = '0;
    sel_full = 1'b0;
    sel_bad  = 1'b0;
    sel_l    = 1'b0;
    for (int k = PMP_CNT - 1; k >= 0; k--) begin
      if (first_hit[k] | last_hit[k]) begin
        sel_hit  = 1'b1;
        sel_idx  = IDX_W'(k);
        sel_full = first_hit[k] & last_hit[k];
        sel_bad  = (s1_r_q & !cfg_q[k].r) | (s1_w_q & !cfg_q[k].w) | (s1_x_q & !cfg_q[k].x);
        sel_l    = cfg_q[k].l;
      end
    end
  end
  assign exc = (s1_prv_q == 2'b10) ? 1'b1 :
               !sel_hit            ? (s1_prv_q != PRV_M) :
               !sel_full           ? 1'b1 :
                                     (sel_bad & ((s1_prv_q != PRV_M) | sel_l));
  assign advance     = !rsp_valid_q || rsp_ready_i;
  assign req_ready_o = !s1_valid_q || advance;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_exc_q   <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_idx_q   <= '0;
    end else begin
      if (req_ready_o) begin
        s1_valid_q <= req_valid_i;
        s1_addr_q  <= req_addr_i;
        s1_size_q  <= req_size_i;
        s1_prv_q   <= req_prv_i;
        s1_r_q     <= req_r_i;
        s1_w_q     <= req_w_i;
        s1_x_q     <= req_x_i;
      end
      if (advance) begin
        rsp_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          rsp_exc_q <= exc;
          rsp_hit_q <= sel_hit;
          rsp_idx_q <= sel_idx;
        end
      end
    end
  end
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_exception_o = rsp_exc_q;
  assign rsp_hit_o       = rsp_hit_q;
  assign rsp_idx_o       = rsp_idx_q;
endmodule

// File: tb/tb_pmp_checker.sv
// tb_pmp_checker: directed and randomized checks of pmp_checker against a region-based reference model
module tb_pmp_checker;
  localparam int N = 16;
`ifdef PMP_NAPOT_EN
  localparam bit NAPOT_EN = 1'b1;
`else
  localparam bit NAPOT_EN = 1'b0;
`endif
  typedef struct { logic [33:0] a; logic [1:0] size; logic [1:0] prv; logic r; logic w; logic x; } req_t;
  typedef struct { logic exc; logic hit; logic [3:0] idx; int acc; } rsp_t;
  logic clk = 0, rst = 1;
  logic csr_we = 0, csr_sel = 0;
  logic [3:0] csr_idx = 0;
  logic [31:0] csr_wdata = 0, csr_rdata;
  logic req_valid = 0, req_ready, req_r = 0, req_w = 0, req_x = 0;
  logic [33:0] req_addr = 0;
  logic [1:0] req_size = 0, req_prv = 0;
  logic rsp_valid, rsp_ready = 1, rsp_exception, rsp_hit;
  logic [3:0] rsp_idx;
  int errors = 0, checks = 0, cyc = 0;
  logic [7:0]  cfg_m [N];
  logic [31:0] addr_m[N];
  req_t stim_q[$];
  rsp_t exp_q[$], got_q[$];

  pmp_checker dut (
    .clk_i(clk), .rst_i(rst), .csr_we_i(csr_we), .csr_sel_i(csr_sel), .csr_idx_i(csr_idx),
    .csr_wdata_i(csr_wdata), .csr_rdata_o(csr_rdata), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_size_i(req_size), .req_prv_i(req_prv), .req_r_i(req_r), .req_w_i(req_w),
    .req_x_i(req_x), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_exception_o(rsp_exception),
    .rsp_hit_o(rsp_hit), .rsp_idx_o(rsp_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic rsp_t model(input req_t q);
    rsp_t o;
    longint unsigned f, l, lo, hi, sz, base;
    int k;
    bit in_f, in_l, full, lk, bad;
    o = '{exc: 1'b0, hit: 1'b0, idx: 4'd0, acc: 0};
    full = 0; lk = 0; bad = 0;
    f = 64'(q.a);
    l = (f + (64'd1 << q.size) - 64'd1) & 64'h3_FFFF_FFFF;
    for (int i = 0; i < N && !o.hit; i++) begin
      lo = 0; hi = 0;
      base = 64'(addr_m[i]) << 2;
      case (cfg_m[i][4:3])
        2'd1: begin lo = (i == 0) ? 64'd0 : (64'(addr_m[i-1]) << 2); hi = base; end
        2'd2: begin lo = base; hi = base + 4; end
        2'd3: if (NAPOT_EN) begin
          k = 0;
          while (k < 32 && addr_m[i][k]) k++;
          sz = 64'd1 << (k + 3);
          lo = base & ~(sz - 1);
          hi = lo + sz;
        end
        default: ;
      endcase
      in_f = f >= lo && f < hi;
      in_l = l >= lo && l < hi;
      if (in_f || in_l) begin
        o.hit = 1; o.idx = i[3:0]; full = in_f && in_l; lk = cfg_m[i][7];
        bad = (q.r && !cfg_m[i][0]) || (q.w && !cfg_m[i][1]) || (q.x && !cfg_m[i][2]);
      end
    end
    if (q.prv == 2'b10) o.exc = 1;
    else if (!o.hit) o.exc = (q.prv != 2'b11);
    else if (!full) o.exc = 1;
    else o.exc = bad && (q.prv != 2'b11 || lk);
    return o;
  endfunction

  task automatic do_reset;
    @(negedge clk);
    rst = 1; req_valid = 0; csr_we = 0; rsp_ready = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < N; i++) begin cfg_m[i] = 0; addr_m[i] = 0; end
  endtask

  task automatic csr_write(input bit sel, input int i, input logic [31:0] d);
    @(negedge clk);
    csr_we = 1; csr_sel = sel; csr_idx = i[3:0]; csr_wdata = d;
    @(posedge clk);
    #1 csr_we = 0;
    if (!sel && !cfg_m[i][7]) cfg_m[i] = {d[7], 2'b00, d[4:3], d[2], d[1] & d[0], d[0]};
    if (sel && !cfg_m[i][7] && !((i < N - 1) && cfg_m[i+1][7] && cfg_m[i+1][4:3] == 2'd1)) addr_m[i] = d;
  endtask

  task automatic rd(input bit sel, input int i);
    @(negedge clk);
    csr_sel = sel; csr_idx = i[3:0];
    #1;
  endtask

  task automatic push(input logic [33:0] a, input logic [1:0] sz, input logic [1:0] prv, input logic r, input logic w, input logic x);
    stim_q.push_back('{a: a, size: sz, prv: prv, r: r, w: w, x: x});
  endtask

  // mode 0: rsp_ready always high (latency checked); 1: low for the first 3 cycles; 2: random
  task automatic run_stream(input int mode);
    int budget, inflight;
    rsp_t e;
    bit stalled;
    logic [6:0] held;
    got_q.delete(); exp_q.delete();
    budget = 0; stalled = 0; held = 0;
    while ((stim_q.size() > 0 || exp_q.size() > 0) && budget < 3000) begin
      @(negedge clk);
      budget++;
      rsp_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (budget > 3) : ($urandom_range(0, 2) != 0);
      req_valid = stim_q.size() > 0;
      if (req_valid) begin
        req_addr = stim_q[0].a; req_size = stim_q[0].size; req_prv = stim_q[0].prv;
        req_r = stim_q[0].r; req_w = stim_q[0].w; req_x = stim_q[0].x;
      end
      #1;
      inflight = exp_q.size();
      checks++;
      if (req_ready !== (inflight < 2 || rsp_ready)) begin
        errors++; $display("FAIL req_ready: got %b want %b (in flight %0d)", req_ready, (inflight < 2 || rsp_ready), inflight);
      end
      if (stalled) begin
        checks++;
        if ({rsp_valid, rsp_exception, rsp_hit, rsp_idx} !== held) begin
          errors++; $display("FAIL rsp_hold: got %h want %h", {rsp_valid, rsp_exception, rsp_hit, rsp_idx}, held);
        end
      end
      if (rsp_valid === 1'b1 && exp_q.size() == 0) begin
        checks++; errors++; $display("FAIL spurious_rsp: got rsp_valid=1 want 0");
      end
      if (rsp_valid === 1'b1 && rsp_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({rsp_exception, rsp_hit, rsp_idx} !== {e.exc, e.hit, e.idx}) begin
          errors++; $display("FAIL rsp: got exc=%b hit=%b idx=%0d want exc=%b hit=%b idx=%0d",
                             rsp_exception, rsp_hit, rsp_idx, e.exc, e.hit, e.idx);
        end
        if (mode == 0) begin
          checks++;
          if (cyc - e.acc != 2) begin errors++; $display("FAIL latency: got %0d want 2", cyc - e.acc); end
        end
        got_q.push_back('{exc: rsp_exception, hit: rsp_hit, idx: rsp_idx, acc: 0});
      end
      stalled = rsp_valid && !rsp_ready;
      held = {rsp_valid, rsp_exception, rsp_hit, rsp_idx};
      if (req_valid && req_ready) begin
        e = model(stim_q.pop_front());
        e.acc = cyc;
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    req_valid = 0; rsp_ready = 1;
    if (budget >= 3000) begin
      checks++; errors++; $display("FAIL stream_timeout: got %0d pending want 0", stim_q.size() + exp_q.size());
      stim_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_reset;
    do_reset;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    checks++; if ({rsp_valid, rsp_exception, rsp_hit, rsp_idx} !== 7'd0) begin
      errors++; $display("FAIL reset_rsp: got %h want 0", {rsp_valid, rsp_exception, rsp_hit, rsp_idx}); end
    rd(0, 0);
    checks++; if (csr_rdata !== 32'd0) begin errors++; $display("FAIL reset_cfg0: got %h want 0", csr_rdata); end
    rd(1, 5);
    checks++; if (csr_rdata !== 32'd0) begin errors++; $display("FAIL reset_addr5: got %h want 0", csr_rdata); end
  endtask

  task automatic test_no_match;
    do_reset;
    push(34'h1000, 2, 2'd0, 1, 0, 0);
    push(34'h1000, 2, 2'd3, 1, 0, 0);
    push(34'h1000, 2, 2'd1, 1, 0, 0);
    push(34'h1000, 2, 2'd2, 1, 0, 0);
    run_stream(0);
    checks++;
    if (got_q.size() != 4) begin errors++; $display("FAIL nomatch_count: got %0d want 4", got_q.size()); end
    else begin
      if ({got_q[0].exc, got_q[0].hit} !== 2'b10) begin errors++; $display("FAIL nomatch_u: got %b want 10", {got_q[0].exc, got_q[0].hit}); end
      if ({got_q[1].exc, got_q[1].hit} !== 2'b00) begin errors++; $display("FAIL nomatch_m: got %b want 00", {got_q[1].exc, got_q[1].hit}); end
      if (got_q[2].exc !== 1'b1) begin errors++; $display("FAIL nomatch_s: got %b want 1", got_q[2].exc); end
      if (got_q[3].exc !== 1'b1) begin errors++; $display("FAIL prv2: got %b want 1", got_q[3].exc); end
      checks += 4;
    end
  endtask

  task automatic test_tor;
    do_reset;
    csr_write(1, 0, 32'h400);
    csr_write(0, 0, 32'h09);
    csr_write(0, 1, 32'h6A);
    rd(0, 0);
    checks++; if (csr_rdata !== 32'h09) begin errors++; $display("FAIL tor_cfg0: got %h want 09", csr_rdata); end
    rd(0, 1);
    checks++; if (csr_rdata !== 32'h08) begin errors++; $display("FAIL cfg_wr_fix: got %h want 08", csr_rdata); end
    push(34'h0FFC, 2, 2'd0, 1, 0, 0);
    push(34'h0FFC, 2, 2'd0, 0, 1, 0);
    push(34'h1000, 2, 2'd0, 1, 0, 0);
    push(34'h0FFE, 2, 2'd0, 1, 0, 0);
    run_stream(0);
    checks++;
    if (got_q.size() != 4) begin errors++; $display("FAIL tor_count: got %0d want 4", got_q.size()); end
    else begin
      if ({got_q[0].exc, got_q[0].hit, got_q[0].idx} !== 6'b010000) begin errors++; $display("FAIL tor_read: got %b want 010000", {got_q[0].exc, got_q[0].hit, got_q[0].idx}); end
      if ({got_q[1].exc, got_q[1].hit} !== 2'b11) begin errors++; $display("FAIL tor_write: got %b want 11", {got_q[1].exc, got_q[1].hit}); end
      if ({got_q[2].exc, got_q[2].hit} !== 2'b10) begin errors++; $display("FAIL tor_above: got %b want 10", {got_q[2].exc, got_q[2].hit}); end
      if ({got_q[3].exc, got_q[3].hit} !== 2'b11) begin errors++; $display("FAIL tor_straddle: got %b want 11", {got_q[3].exc, got_q[3].hit}); end
      checks += 4;
    end
  endtask

  task automatic test_na4;
    do_reset;
    csr_write(1, 0, 32'h400);
    csr_write(0, 0, 32'h11);
    push(34'h1002, 2, 2'd0, 1, 0, 0);
    push(34'h1000, 2, 2'd0, 1, 0, 0);
    run_stream(0);
    checks++;
    if (got_q.size() != 2) begin errors++; $display("FAIL na4_count: got %0d want 2", got_q.size()); end
    else begin
      if ({got_q[0].exc, got_q[0].hit} !== 2'b11) begin errors++; $display("FAIL na4_partial: got %b want 11", {got_q[0].exc, got_q[0].hit}); end
      if ({got_q[1].exc, got_q[1].hit} !== 2'b01) begin errors++; $display("FAIL na4_full: got %b want 01", {got_q[1].exc, got_q[1].hit}); end
      checks += 2;
    end
  endtask

  task automatic test_lock;
    do_reset;
    csr_write(1, 0, 32'h100);
    csr_write(1, 1, 32'h400);
    csr_write(0, 1, 32'h88);
    csr_write(1, 0, 32'h200);
    csr_write(1, 1, 32'h500);
    csr_write(0, 1, 32'h00);
    rd(1, 0);
    checks++; if (csr_rdata !== 32'h100) begin errors++; $display("FAIL lock_addr0: got %h want 100", csr_rdata); end
    rd(1, 1);
    checks++; if (csr_rdata !== 32'h400) begin errors++; $display("FAIL lock_addr1: got %h want 400", csr_rdata); end
    rd(0, 1);
    checks++; if (csr_rdata !== 32'h88) begin errors++; $display("FAIL lock_cfg1: got %h want 88", csr_rdata); end
    push(34'h800, 2, 2'd3, 1, 0, 0);
    push(34'h2000, 2, 2'd3, 1, 0, 0);
    run_stream(0);
    checks++;
    if (got_q.size() != 2) begin errors++; $display("FAIL lock_count: got %0d want 2", got_q.size()); end
    else begin
      if ({got_q[0].exc, got_q[0].hit, got_q[0].idx} !== 6'b110001) begin errors++; $display("FAIL lock_m_read: got %b want 110001", {got_q[0].exc, got_q[0].hit, got_q[0].idx}); end
      if ({got_q[1].exc, got_q[1].hit} !== 2'b00) begin errors++; $display("FAIL m_nomatch: got %b want 00", {got_q[1].exc, got_q[1].hit}); end
      checks += 2;
    end
  endtask

  task automatic test_napot;
    do_reset;
    csr_write(1, 0, 32'h3FF);
    csr_write(0, 0, 32'h19);
    push(34'h1FF0, 2, 2'd0, 1, 0, 0);
    push(34'h2000, 2, 2'd0, 1, 0, 0);
    run_stream(0);
    checks++;
    if (got_q.size() != 2) begin errors++; $display("FAIL napot_count: got %0d want 2", got_q.size()); end
    else begin
      if ({got_q[0].exc, got_q[0].hit} !== {!NAPOT_EN, NAPOT_EN}) begin errors++; $display("FAIL napot_in: got %b want %b", {got_q[0].exc, got_q[0].hit}, {!NAPOT_EN, NAPOT_EN}); end
      if ({got_q[1].exc, got_q[1].hit} !== 2'b10) begin errors++; $display("FAIL napot_out: got %b want 10", {got_q[1].exc, got_q[1].hit}); end
      checks += 2;
    end
  endtask

  task automatic test_back_to_back;
    do_reset;
    csr_write(1, 0, 32'h400);
    csr_write(0, 0, 32'h09);
    push(34'h100, 2, 2'd0, 1, 0, 0);
    push(34'h100, 2, 2'd0, 0, 1, 0);
    push(34'h2000, 2, 2'd0, 1, 0, 0);
    run_stream(1);
    checks++;
    if (got_q.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", got_q.size()); end
    else begin
      if ({got_q[0].exc, got_q[1].exc, got_q[2].exc} !== 3'b011) begin errors++; $display("FAIL b2b_order: got %b want 011", {got_q[0].exc, got_q[1].exc, got_q[2].exc}); end
      if ({got_q[0].hit, got_q[1].hit, got_q[2].hit} !== 3'b110) begin errors++; $display("FAIL b2b_hits: got %b want 110", {got_q[0].hit, got_q[1].hit, got_q[2].hit}); end
      checks += 2;
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    csr_write(1, 0, 32'h400);
    csr_write(0, 0, 32'h09);
    @(negedge clk);
    rsp_ready = 1; req_valid = 1; req_addr = 34'h100; req_size = 2; req_prv = 0; req_r = 1; req_w = 0; req_x = 0;
    @(negedge clk);
    req_valid = 0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_early: got %b want 0", rsp_valid); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < N; i++) begin cfg_m[i] = 0; addr_m[i] = 0; end
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL mid_discard: got valid=%b ready=%b want 0 1", rsp_valid, req_ready); end
      @(negedge clk);
    end
    rd(0, 0);
    checks++; if (csr_rdata !== 32'd0) begin errors++; $display("FAIL mid_cfg_clr: got %h want 0", csr_rdata); end
  endtask

  task automatic test_random;
    logic [31:0] c;
    logic [2:0] rwx;
    do_reset;
    for (int i = 0; i < N; i++) csr_write(1, i, $urandom_range(0, 'h1000));
    for (int i = 0; i < N; i++) begin
      c = $urandom;
      if ($urandom_range(0, 5) != 0) c[7] = 1'b0;
      csr_write(0, i, c);
    end
    for (int i = 0; i < N; i++) if ($urandom_range(0, 1) == 1) csr_write(1, i, $urandom_range(0, 'h1000));
    for (int i = 0; i < N; i++) begin
      rd(0, i);
      checks++; if (csr_rdata !== {24'd0, cfg_m[i]}) begin errors++; $display("FAIL rand_cfg%0d: got %h want %h", i, csr_rdata, cfg_m[i]); end
      rd(1, i);
      checks++; if (csr_rdata !== addr_m[i]) begin errors++; $display("FAIL rand_addr%0d: got %h want %h", i, csr_rdata, addr_m[i]); end
    end
    for (int n = 0; n < 300; n++) begin
      rwx = 3'b001 << $urandom_range(0, 2);
      push(($urandom_range(0, 9) == 0) ? {$urandom_range(0, 3), $urandom} : 34'($urandom_range(0, 'h5000)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), rwx[0], rwx[1], rwx[2]);
    end
    run_stream(2);
    checks++; if (got_q.size() != 300) begin errors++; $display("FAIL rand_count: got %0d want 300", got_q.size()); end
  endtask

  initial begin
    test_reset;
    test_no_match;
    test_tor;
    test_na4;
    test_lock;
    test_napot;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
